rk4_fpga: RTL and testbench
===========================

Name: rk4_fpga

Overview:
- Fixed-point fourth-order Runge-Kutta solver for dy/dx = f(x,y) = x + y on the Basys 3 board.
- Pressing `btn` runs N_STEPS RK4 steps of size H, starting from (X0, Y0).
- The resulting y is shown in hex on the four-digit seven-segment display.
- `x_out`, `y_out` and `done` are exported for simulation and debug.

Parameters:
- X0, 32'h0000_0000: initial x, signed Q16.16.
- Y0, 32'h0001_0000: initial y, signed Q16.16 (1.0).
- H, 32'h0000_4000: step size, signed Q16.16 (0.25).
- N_STEPS, 4: number of RK4 steps per run, 1..65535.
- REFRESH_BITS, 18: width of the display-scan counter; the top 2 bits select the digit.

Ports:
- CLOCK, input, 1: 100 MHz system clock. All logic is on the rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- btn, input, 1: start button, active-high, asynchronous to CLOCK.
- btn_r, input, 1: clear button, active-high, asynchronous to CLOCK.
- sseg, output, 8: segments, active-low. [6:0] = g..a, [7] = dp, always 1 (off).
- DISP_EN, output, 4: digit anodes, active-low. [0] = rightmost digit.
- x_out, output, 32: current x, Q16.16.
- y_out, output, 32: current y, Q16.16.
- done, output, 1: high when the last run completed.

Behaviour:
- Reset (RESET_N=0, async), all held until release:
  - x_out=X0, y_out=Y0, done=0.
  - FSM in IDLE, step counter=0, scan counter=0, synchronizers cleared.
- Input conditioning:
  - btn and btn_r each pass through a 2-FF synchronizer.
  - Start = rising edge of synchronized btn (1-cycle pulse).
  - Clear = synchronized btn_r level.
  - No debounce: extra edges while the FSM is busy are ignored.
- FSM states: IDLE, K1, K2, K3, K4, UPD, DONE.
  - IDLE --start--> K1. On this transition x=X0, y=Y0, step counter=0, done=0.
  - Each state K1..K4 and UPD lasts exactly 1 cycle, so one step takes 5 cycles.
  - UPD: if the counter has reached N_STEPS-1 → DONE, else counter+1 → K1.
  - DONE: done=1. start → K1 (restart from X0,Y0, done cleared); otherwise stay.
  - Clear in any state → IDLE with x=X0, y=Y0, done=0. Clear has priority over start in the same cycle.
- Arithmetic:
  - All values signed Q16.16.
  - mul(a,b) = bits [47:16] of the signed 64-bit product (arithmetic truncation).
  - HH = H>>>1.
  - K1: k1 = x + y.
  - K2: k2 = (x+HH) + (y + mul(HH,k1)).
  - K3: k3 = (x+HH) + (y + mul(HH,k2)).
  - K4: k4 = (x+H) + (y + mul(H,k3)).
  - UPD: S = k1 + 2k2 + 2k3 + k4; y += mul(H,S)/6 (signed divide, truncate toward zero); x += H.
  - Adds wrap modulo 2^32; no saturation or overflow flag.
  - x_out and y_out change only in UPD (and on reset, start or clear).
- Display:
  - Shows y_out[23:16] as 2 hex digits, then y_out[15:8] as 2 hex digits (8.8 view).
  - The free-running scan counter's top 2 bits select the digit: 0 = rightmost (DISP_EN=4'b1110) … 3 = leftmost (4'b0111).
  - Exactly one anode is low at a time.
  - Standard hex glyphs 0-F.
  - The display always shows the current y_out, including mid-run values.

Test Plan:
- Reset: RESET_N=0 → x_out=0, y_out=32'h0001_0000, done=0. After release, DISP_EN cycles 1110→1101→1011→0111, digits read 0100.
- Single step (N_STEPS=1): btn high for 10 ms → after 2 sync cycles + 5 cycles, x_out=32'h0000_4000, y_out=32'h0001_516A, done=1. Display reads 0151.
- Default run (N_STEPS=4): btn pulse → done rises exactly 2+20 cycles after the btn edge, x_out=32'h0001_0000. y_out is bit-exact against the spec arithmetic model (≈3.4366).
- Clear: btn_r=1 during K3 of step 2 → next cycle IDLE, x_out=0, y_out=32'h0001_0000, done=0. No further updates.
- Restart: after done, btn pulse again → identical result to the first run.
- Async reset mid-run: RESET_N low between clock edges → outputs return to reset values immediately, with no clock required.

Source files
------------

// File: rtl/rk4_fpga.sv
// Fixed-point RK4 solver for dy/dx = x + y (signed Q16.16), with the running y
// shown as an 8.8 hex view on a four-digit multiplexed seven-segment display.
module rk4_fpga #(
   parameter logic signed [31:0] X0           = 32'sh0000_0000,
   parameter logic signed [31:0] Y0           = 32'sh0001_0000,
   parameter logic signed [31:0] H            = 32'sh0000_4000,
   parameter int                 N_STEPS      = 4,
   parameter int                 REFRESH_BITS = 18
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        btn,
   input  logic        btn_r,
   output logic [7:0]  sseg,
   output logic [3:0]  DISP_EN,
   output logic [31:0] x_out,
   output logic [31:0] y_out,
   output logic        done
);

   typedef enum logic [2:0] {S_IDLE, S_K1, S_K2, S_K3, S_K4, S_UPD, S_DONE} state_t;

   localparam logic signed [31:0] HH   = H >>> 1;
   localparam logic [15:0]        LAST = 16'(N_STEPS - 1);

   state_t                  state_q, state_d;
   logic                    btn_s1, btn_s2, clr_s1, clr_s2;
   logic                    start, clear, load_init;
   logic [15:0]             step_cnt;
   logic signed [31:0]      x_q, y_q, k1, k2, k3, k4;
   logic signed [31:0]      k_eval, s_sum, y_inc;
   logic [REFRESH_BITS-1:0] scan;
   logic [1:0]              digit_sel;
   logic [3:0]              nibble;
   logic [6:0]              seg;

   function automatic logic signed [31:0] mul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [63:0] p;
      p = 64'(a) * 64'(b);
      return p[47:16];
   endfunction

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         clr_s1 <= 1'b0;
         clr_s2 <= 1'b0;
      end else begin
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         clr_s1 <= btn_r;
         clr_s2 <= clr_s1;
      end
   end

   // Start is the rise seen across the two synchronizer stages, so the FSM
   // leaves IDLE on the second clock edge after btn goes high.
   assign start = btn_s1 & ~btn_s2;
   assign clear = clr_s2;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_init = 1'b0;
      if (clear) begin
         state_d   = S_IDLE;
         load_init = 1'b1;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start) begin
               state_d   = S_K1;
               load_init = 1'b1;
            end
            S_K1:    state_d = S_K2;
            S_K2:    state_d = S_K3;
            S_K3:    state_d = S_K4;
            S_K4:    state_d = S_UPD;
            S_UPD:   state_d = (step_cnt == LAST) ? S_DONE : S_K1;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // One slope evaluation per K state; the same adder tree serves all four.
   always_comb begin
      k_eval = x_q + y_q;
      case (state_q)
         S_K2:    k_eval = (x_q + HH) + (y_q + mul(HH, k1));
         S_K3:    k_eval = (x_q + HH) + (y_q + mul(HH, k2));
         S_K4:    k_eval = (x_q + H)  + (y_q + mul(H, k3));
         default: k_eval = x_q + y_q;
      endcase
      s_sum = k1 + (k2 <<< 1) + (k3 <<< 1) + k4;
      y_inc = mul(H, s_sum) / 32'sd6;
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         x_q      <= X0;
         y_q      <= Y0;
         done     <= 1'b0;
         step_cnt <= '0;
         k1       <= '0;
         k2       <= '0;
         k3       <= '0;
         k4       <= '0;
      end else if (load_init) begin
         x_q      <= X0;
         y_q      <= Y0;
         done     <= 1'b0;
         step_cnt <= '0;
      end else begin
         case (state_q)
            S_K1: k1 <= k_eval;
            S_K2: k2 <= k_eval;
            S_K3: k3 <= k_eval;
            S_K4: k4 <= k_eval;
            S_UPD: begin
               x_q <= x_q + H;
               y_q <= y_q + y_inc;
               if (step_cnt == LAST) done <= 1'b1;
               else                  step_cnt <= step_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign x_out = x_q;
   assign y_out = y_q;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) scan <= '0;
      else          scan <= scan + 1'b1;
   end

   assign digit_sel = scan[REFRESH_BITS-1 -: 2];

   always_comb begin
      case (digit_sel)
         2'd0:    nibble = y_q[11:8];
         2'd1:    nibble = y_q[15:12];
         2'd2:    nibble = y_q[19:16];
         default: nibble = y_q[23:20];
      endcase
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
   end

   assign DISP_EN = ~(4'b0001 << digit_sel);
   assign sseg    = {1'b1, seg};

endmodule

// File: tb/tb_rk4_fpga.sv
// Bench for rk4_fpga: two instances (4-step and 1-step runs) checked against a
// plain-arithmetic RK4 model, display scan, clear, restart and async reset.
module tb_rk4_fpga;

   localparam logic [31:0] X0 = 32'h0000_0000;
   localparam logic [31:0] Y0 = 32'h0001_0000;
   localparam logic [31:0] H  = 32'h0000_4000;

   logic        CLOCK, RESET_N, btn, btn_r;
   logic [7:0]  sseg4, sseg1;
   logic [3:0]  en4, en1;
   logic [31:0] x4, y4, x1, y1;
   logic        done4, done1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rel_cyc = 0;
   int mx [0:4];
   int my [0:4];

   // Active-high segment patterns, bit 0 = a .. bit 6 = g.
   logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   rk4_fpga #(.N_STEPS(4), .REFRESH_BITS(4)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .btn(btn), .btn_r(btn_r),
      .sseg(sseg4), .DISP_EN(en4), .x_out(x4), .y_out(y4), .done(done4));

   rk4_fpga #(.N_STEPS(1), .REFRESH_BITS(4)) dut1 (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .btn(btn), .btn_r(btn_r),
      .sseg(sseg1), .DISP_EN(en1), .x_out(x1), .y_out(y1), .done(done1));

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic int qmul(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return int'(p >>> 16);
   endfunction

   task automatic build_model();
      int x, y, h, hh, k1, k2, k3, k4;
      x = int'(X0); y = int'(Y0); h = int'(H); hh = h >>> 1;
      mx[0] = x; my[0] = y;
      for (int i = 1; i <= 4; i++) begin
         k1 = x + y;
         k2 = (x + hh) + (y + qmul(hh, k1));
         k3 = (x + hh) + (y + qmul(hh, k2));
         k4 = (x + h) + (y + qmul(h, k3));
         y  = y + qmul(h, k1 + 2 * k2 + 2 * k3 + k4) / 6;
         x  = x + h;
         mx[i] = x; my[i] = y;
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      logic [1:0] dig;
      logic [3:0] nib;
      RESET_N = 1'b0; btn = 1'b0; btn_r = 1'b0;
      tick(); tick();
      total++; if (x4 !== X0)   begin bad++; $display("FAIL reset_x: actual=%h required=%h", x4, X0); end
      total++; if (y4 !== Y0)   begin bad++; $display("FAIL reset_y: actual=%h required=%h", y4, Y0); end
      total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done: actual=%b required=0", done4); end
      total++; if (y1 !== Y0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_dut1: actual=%h/%b required=%h/0", y1, done1, Y0); end
      total++; if (en4 !== 4'b1110) begin bad++; $display("FAIL reset_en: actual=%b required=1110", en4); end
      RESET_N = 1'b1;
      rel_cyc = cyc;
      for (int k = 1; k <= 16; k++) begin
         tick();
         dig = 2'(((cyc - rel_cyc) & 15) >> 2);
         nib = 4'((Y0 >> (8 + 4 * dig)) & 15);
         total++;
         if (en4 !== ~(4'b0001 << dig) || sseg4 !== {1'b1, ~glyph[nib]}) begin
            bad++;
            $display("FAIL reset_display k=%0d: actual=%b/%h required=%b/%h", k, en4, sseg4,
                     ~(4'b0001 << dig), {1'b1, ~glyph[nib]});
         end
      end
   endtask

   task automatic test_single_step();
      int hold;
      logic [1:0] dig;
      logic [3:0] nib;
      hold = $urandom_range(1, 12);
      btn = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         if (e == 6) begin
            total++; if (done1 !== 1'b0) begin bad++; $display("FAIL single_early_done: actual=%b required=0", done1); end
         end
         if (e == 7) begin
            total++; if (done1 !== 1'b1) begin bad++; $display("FAIL single_done: actual=%b required=1", done1); end
            total++; if (x1 !== H) begin bad++; $display("FAIL single_x: actual=%h required=%h", x1, H); end
            total++; if (y1 !== 32'h0001_516A) begin bad++; $display("FAIL single_y: actual=%h required=0001516a", y1); end
            total++; if (y1 !== 32'(my[1])) begin bad++; $display("FAIL single_y_model: actual=%h required=%h", y1, my[1]); end
         end
         if (e >= 8) begin
            dig = 2'(((cyc - rel_cyc) & 15) >> 2);
            nib = 4'((my[1] >> (8 + 4 * dig)) & 15);
            total++;
            if (en1 !== ~(4'b0001 << dig) || sseg1 !== {1'b1, ~glyph[nib]}) begin
               bad++;
               $display("FAIL single_display e=%0d: actual=%b/%h required=%b/%h", e, en1, sseg1,
                        ~(4'b0001 << dig), {1'b1, ~glyph[nib]});
            end
         end
         if (e == 22) begin
            total++; if (done4 !== 1'b1) begin bad++; $display("FAIL first_run_done: actual=%b required=1", done4); end
         end
         if (e == hold) btn = 1'b0;
      end
   endtask

   task automatic test_default_run();
      int hold, g, n;
      hold = $urandom_range(1, 6);
      g    = $urandom_range(8, 17);
      btn  = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         tick();
         if (e >= 2 && e <= 22) begin
            n = (e - 2) / 5;
            total++;
            if (x4 !== 32'(mx[n]) || y4 !== 32'(my[n])) begin
               bad++;
               $display("FAIL run_xy e=%0d: actual=%h/%h required=%h/%h", e, x4, y4, mx[n], my[n]);
            end
            total++;
            if (done4 !== (e == 22)) begin
               bad++;
               $display("FAIL run_done e=%0d: actual=%b required=%b", e, done4, (e == 22));
            end
         end
         if (e > 22) begin
            total++; if (done4 !== 1'b1 || x4 !== 32'h0001_0000) begin bad++; $display("FAIL run_hold e=%0d: actual=%b/%h required=1/00010000", e, done4, x4); end
         end
         if (e == hold) btn = 1'b0;
         if (e == g) btn = 1'b1;
         if (e == g + 1) btn = 1'b0;
      end
   endtask

   task automatic test_clear();
      int hold;
      hold = $urandom_range(1, 5);
      btn  = 1'b1;
      for (int e = 1; e <= 45; e++) begin
         tick();
         if (e == 9) begin
            total++; if (x4 !== 32'(mx[1]) || done4 !== 1'b0) begin bad++; $display("FAIL clear_pre: actual=%h/%b required=%h/0", x4, done4, mx[1]); end
         end
         if (e == 10) begin
            total++; if (x4 !== X0 || y4 !== Y0 || done4 !== 1'b0) begin bad++; $display("FAIL clear_now: actual=%h/%h/%b required=%h/%h/0", x4, y4, done4, X0, Y0); end
            total++; if (done1 !== 1'b0 || x1 !== X0) begin bad++; $display("FAIL clear_dut1: actual=%b/%h required=0/%h", done1, x1, X0); end
            btn_r = 1'b0;
         end
         if (e == 30 || e == 45) begin
            total++; if (x4 !== X0 || y4 !== Y0 || done4 !== 1'b0) begin bad++; $display("FAIL clear_stay e=%0d: actual=%h/%h/%b required=%h/%h/0", e, x4, y4, done4, X0, Y0); end
         end
         if (e == hold) btn = 1'b0;
         if (e == 7) btn_r = 1'b1;
      end
   endtask

   task automatic test_restart();
      logic [31:0] ya;
      ya = '0;
      for (int run = 0; run < 2; run++) begin
         btn = 1'b1;
         for (int e = 1; e <= 26; e++) begin
            tick();
            if (run == 1 && e == 2) begin
               total++; if (done4 !== 1'b0 || x4 !== X0) begin bad++; $display("FAIL restart_init: actual=%b/%h required=0/%h", done4, x4, X0); end
            end
            if (e == 22) begin
               total++; if (done4 !== 1'b1 || x4 !== 32'(mx[4])) begin bad++; $display("FAIL restart_done run=%0d: actual=%b/%h required=1/%h", run, done4, x4, mx[4]); end
               total++; if (y4 !== 32'(my[4])) begin bad++; $display("FAIL restart_y run=%0d: actual=%h required=%h", run, y4, my[4]); end
               if (run == 0) ya = y4;
               else begin
                  total++; if (y4 !== ya) begin bad++; $display("FAIL restart_same: actual=%h required=%h", y4, ya); end
               end
            end
            if (e == $urandom_range(1, 8)) btn = 1'b0;
            if (e == 9) btn = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      int r;
      r   = $urandom_range(8, 18);
      btn = 1'b1;
      for (int e = 1; e <= r; e++) begin
         tick();
         if (e == 3) btn = 1'b0;
      end
      #3;
      RESET_N = 1'b0;
      #1;
      total++; if (x4 !== X0 || y4 !== Y0 || done4 !== 1'b0) begin bad++; $display("FAIL async_rst: actual=%h/%h/%b required=%h/%h/0", x4, y4, done4, X0, Y0); end
      total++; if (x1 !== X0 || y1 !== Y0 || done1 !== 1'b0) begin bad++; $display("FAIL async_rst_dut1: actual=%h/%h/%b required=%h/%h/0", x1, y1, done1, X0, Y0); end
      total++; if (en4 !== 4'b1110) begin bad++; $display("FAIL async_rst_en: actual=%b required=1110", en4); end
      tick(); tick();
      RESET_N = 1'b1;
      rel_cyc = cyc;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e == 25) begin
            total++; if (x4 !== X0 || done4 !== 1'b0) begin bad++; $display("FAIL async_idle: actual=%h/%b required=%h/0", x4, done4, X0); end
         end
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      btn     = 1'b0;
      btn_r   = 1'b0;
      build_model();
      test_reset();
      test_single_step();
      test_default_run();
      test_clear();
      test_restart();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
